// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: redirect, instruction-memory and decode-side signals of the fetch unit.
// master = fetch unit side, slave = surrounding core / memory side.
// fetch_misaligned_o exists only when FETCH_ALIGN_CHECK_EN is defined.
interface ifu_fetch_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_addr_o;
    logic        id_ready_i;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned_o;
`endif

    modport master (
`ifdef FETCH_ALIGN_CHECK_EN
        output fetch_misaligned_o,
`endif
        input  redirect_i, redirect_pc_i,
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output id_valid_o, id_inst_o, id_addr_o,
        input  id_ready_i
    );

    modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
        input  fetch_misaligned_o,
`endif
        output redirect_i, redirect_pc_i,
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  id_valid_o, id_inst_o, id_addr_o,
        output id_ready_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32I instruction fetch unit. Holds the fetch PC, issues word fetches,
// buffers returned words in an in-order FIFO and hands {inst, addr} to decode.
// A redirect flushes the FIFO; responses already in flight are counted and dropped.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect target produces
// a single NOP entry flagged by fetch_misaligned_o and halts fetching).
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master bus
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic        run;

    logic [31:0] fpc_reg, rpc_reg, last_addr_reg;
    logic [CW-1:0] count_reg, outst_reg, drop_reg;
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [31:0] inst_mem [FIFO_DEPTH];
    logic [31:0] addr_mem [FIFO_DEPTH];

    logic        redirect, rvalid, gnt, req, halt, empty, dropping;
    logic        pop_raw, pop, accept, push_resp, push_mis, push;
    logic [31:0] redir_pc, push_inst, push_addr, id_inst, id_addr;
    logic [CW:0] credit;

    // State register: IDLE for the single cycle after reset, RUN afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next state: IDLE always advances to RUN, RUN is terminal
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // State outputs: fetching is only permitted in RUN
    always_comb begin
        run = (state_reg == ST_RUN);
    end

    assign redirect  = bus.redirect_i;
    assign rvalid    = bus.imem_rvalid_i;
    assign redir_pc  = {bus.redirect_pc_i[31:2], 2'b00};
    assign empty     = (count_reg == '0);
    assign pop_raw   = !empty && bus.id_ready_i;
    assign pop       = pop_raw && !redirect;
    // A head leaving this cycle frees its slot, which keeps single-cycle memory at
    // one instruction per cycle. During a redirect the flush frees it anyway.
    assign credit    = {1'b0, count_reg} + {1'b0, outst_reg} - {{CW{1'b0}}, pop_raw};
    assign req       = run && !halt && (credit < DEPTH_C);
    assign gnt       = req && bus.imem_gnt_i;
    assign dropping  = (drop_reg != '0);
    assign accept    = rvalid && !dropping;
    assign push_resp = accept && !redirect;
    assign push      = push_resp || push_mis;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        halt_reg, mis_pend_reg, redir_mis;
    logic [31:0] mis_pc_reg;
    logic        mis_mem [FIFO_DEPTH];

    assign redir_mis = |bus.redirect_pc_i[1:0];
    assign halt      = halt_reg;
    assign push_mis  = mis_pend_reg && !redirect;
    assign push_inst = push_mis ? NOP : bus.imem_rdata_i;
    assign push_addr = push_mis ? mis_pc_reg : rpc_reg;

    // Misaligned target: halt fetching and queue one flagged NOP the cycle after the flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_reg     <= 1'b0;
            mis_pend_reg <= 1'b0;
            mis_pc_reg   <= 32'h0;
        end else begin
            mis_pend_reg <= redirect && redir_mis;
            if (redirect) begin
                halt_reg   <= redir_mis;
                mis_pc_reg <= bus.redirect_pc_i;
            end
        end
    end

    // Per-entry misalignment flag, written alongside the data entry
    always_ff @(posedge clk) begin
        if (push) mis_mem[wr_ptr_reg] <= push_mis;
    end

    assign bus.fetch_misaligned_o = !empty && mis_mem[rd_ptr_reg];
`else
    logic unused_pc_bits;

    assign unused_pc_bits = |bus.redirect_pc_i[1:0];
    assign halt           = 1'b0;
    assign push_mis       = 1'b0;
    assign push_inst      = bus.imem_rdata_i;
    assign push_addr      = rpc_reg;
`endif

    // In-flight bookkeeping: outstanding fetches and responses still to be discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_reg <= '0;
            drop_reg  <= '0;
        end else begin
            outst_reg <= outst_reg + CW'(gnt) - CW'(rvalid);
            if (redirect)
                drop_reg <= outst_reg + CW'(gnt) - CW'(rvalid);
            else if (rvalid && dropping)
                drop_reg <= drop_reg - CW'(1);
        end
    end

    // Fetch PC advances per grant, response PC per accepted response; both reload on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_reg <= RESET_PC;
            rpc_reg <= RESET_PC;
        end else if (redirect) begin
            fpc_reg <= redir_pc;
            rpc_reg <= redir_pc;
        end else begin
            if (gnt)    fpc_reg <= fpc_reg + 32'd4;
            if (accept) rpc_reg <= rpc_reg + 32'd4;
        end
    end

    // FIFO pointers and occupancy; a redirect discards everything including this cycle's push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; occupancy guards the contents so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= push_inst;
            addr_mem[wr_ptr_reg] <= push_addr;
        end
    end

    // Remember the last presented address so it holds while the FIFO is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_addr_reg <= 32'h0;
        else        last_addr_reg <= id_addr;
    end

    // Decode-side view of the head entry; NOP when empty, no bypass from rvalid
    always_comb begin
        id_inst = NOP;
        id_addr = last_addr_reg;
        if (!empty) begin
            id_inst = inst_mem[rd_ptr_reg];
            id_addr = addr_mem[rd_ptr_reg];
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fpc_reg;
    assign bus.id_valid_o  = !empty;
    assign bus.id_inst_o   = id_inst;
    assign bus.id_addr_o   = id_addr;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed sequence plus randomized traffic for ifu_fetch.
// The reference model is the expected program-order stream: after reset or a
// redirect to P, decode must see P, P+4, ... with the memory's word for each
// address; the memory model grants and returns responses in order.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, acc_cnt = 0;
    logic [31:0] exp_fpc, exp_pc, mis_pc;
    bit   blank_next = 1'b0;
    int   mis_state = 0;
    logic s_req, s_gnt, s_rvalid, s_valid, s_ready, s_mis;
    logic [31:0] s_addr, s_vaddr, s_vinst;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after negedge, sample, check, update model.
    task automatic step(input bit redir, input logic [31:0] pc);
        logic [31:0] pcm;
        bit pc_mis;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = pc;
        bus.imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        bus.id_ready_i    = ($urandom_range(0, 99) < rdy_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = memword(mq[0].addr);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
        #1;
        s_req = bus.imem_req_o;   s_addr = bus.imem_addr_o; s_gnt = bus.imem_gnt_i;
        s_rvalid = bus.imem_rvalid_i; s_ready = bus.id_ready_i;
        s_valid = bus.id_valid_o; s_vaddr = bus.id_addr_o;  s_vinst = bus.id_inst_o;
`ifdef FETCH_ALIGN_CHECK_EN
        s_mis = bus.fetch_misaligned_o;
`else
        s_mis = 1'b0;
`endif
        chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
        if (s_req && s_gnt) chk("fetch_addr", s_addr, exp_fpc);
        if (mis_state != 0) chk("halted_req", {31'd0, s_req}, 32'd0);
        if (blank_next) chk("valid_after_redirect", {31'd0, s_valid}, 32'd0);
        if (!s_valid) begin
            chk("nop_when_empty", s_vinst, NOP);
        end else if (mis_state != 0) begin
            chk("mis_entry_once", 32'(mis_state), 32'd1);
            chk("mis_entry_addr", s_vaddr, mis_pc);
            chk("mis_entry_inst", s_vinst, NOP);
            chk("mis_flag", {31'd0, s_mis}, 32'd1);
        end else begin
            chk("id_addr", s_vaddr, exp_pc);
            chk("id_inst", s_vinst, memword(exp_pc));
            chk("mis_flag_clear", {31'd0, s_mis}, 32'd0);
        end
        if (s_valid && s_ready && !redir) begin
            acc_cnt++;
            $display("cyc %0d: decode accepts addr=%h inst=%h", cyc, s_vaddr, s_vinst);
            if (mis_state != 0) mis_state = 2;
            else exp_pc = exp_pc + 32'd4;
        end
        if (s_rvalid) void'(mq.pop_front());
        if (s_req && s_gnt) begin
            mq.push_back('{s_addr, cyc + $urandom_range(lat_min, lat_max)});
            exp_fpc = exp_fpc + 32'd4;
        end
        chk("outstanding_bound", 32'(mq.size() <= DEPTH), 32'd1);
        if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
            pc_mis = |pc[1:0];
            pcm    = pc;
`else
            pc_mis = 1'b0;
            pcm    = {pc[31:2], 2'b00};
`endif
            exp_fpc   = {pcm[31:2], 2'b00};
            exp_pc    = pcm;
            mis_pc    = pcm;
            mis_state = pc_mis ? 1 : 0;
        end
        blank_next = redir;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0; bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.id_ready_i = 1'b0;
        mq.delete();
        #1;
        chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("rst_addr", bus.imem_addr_o, RESET_PC);
        chk("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
        chk("rst_inst", bus.id_inst_o, NOP);
        chk("rst_id_addr", bus.id_addr_o, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_mis", {31'd0, bus.fetch_misaligned_o}, 32'd0);
`endif
        repeat (hold) @(negedge clk);
        exp_fpc = RESET_PC; exp_pc = RESET_PC; mis_pc = RESET_PC;
        blank_next = 1'b0; mis_state = 0; cyc = 0;
        rst_n = 1'b1;
    endtask

    task automatic startup();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        step(1'b0, 32'h0); chk("idle_no_req", {31'd0, s_req}, 32'd0);
        step(1'b0, 32'h0); chk("first_req", {31'd0, s_req}, 32'd1);
        chk("first_addr", s_addr, RESET_PC);
        step(1'b0, 32'h0); chk("no_bypass", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'h0); chk("first_valid", {31'd0, s_valid}, 32'd1);
        chk("first_id_addr", s_vaddr, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0);
            chk("throughput", {31'd0, s_valid && s_req && s_gnt}, 32'd1);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 32'h0);
            if (s_valid) begin found = 1'b1; break; end
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bit found;
        logic [31:0] rpc;
        apply_reset(3);
        startup();

        // Decode stall: FIFO fills, fetching stops, then drains in order
        rdy_pct = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        chk("stall_req_low", {31'd0, s_req}, 32'd0);
        chk("stall_valid", {31'd0, s_valid}, 32'd1);
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

        // Latency 3 with two fetches outstanding, then redirect to 0x100
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 32'h0);
            if (mq.size() == 2) begin found = 1'b1; break; end
        end
        chk("two_outstanding", {31'd0, found}, 32'd1);
        step(1'b1, 32'h0000_0100);
        wait_valid("redir100_valid");
        chk("redir100_addr", s_vaddr, 32'h0000_0100);
        chk("redir100_inst", s_vinst, memword(32'h0000_0100));

        // Redirect coinciding with grant, response and pop
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0300);
        chk("coincide", {29'd0, s_req && s_gnt, s_rvalid, s_valid && s_ready}, 32'd7);
        step(1'b0, 32'h0);
        chk("post_redir_req", {31'd0, s_req}, 32'd1);
        chk("post_redir_addr", s_addr, 32'h0000_0300);
        wait_valid("redir300_valid");
        chk("redir300_addr", s_vaddr, 32'h0000_0300);

        // Reset asserted mid-stream
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
        apply_reset(2);
        startup();

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect: one flagged NOP entry, fetching halts until the next redirect
        rdy_pct = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0102);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("mis_valid", {31'd0, s_valid}, 32'd1);
        chk("mis_addr", s_vaddr, 32'h0000_0102);
        chk("mis_inst", s_vinst, NOP);
        chk("mis_out", {31'd0, s_mis}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            chk("mis_no_req", {31'd0, s_req}, 32'd0);
        end
        rdy_pct = 100;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("mis_drained", {31'd0, s_valid}, 32'd0);
        chk("mis_still_halted", {31'd0, s_req}, 32'd0);
        step(1'b1, 32'h0000_0200);
        wait_valid("redir200_valid");
        chk("redir200_addr", s_vaddr, 32'h0000_0200);
        chk("redir200_mis", {31'd0, s_mis}, 32'd0);
`else
        // Low redirect bits are ignored: 0x102 fetches from 0x100
        step(1'b1, 32'h0000_0102);
        wait_valid("redir102_valid");
        chk("redir102_addr", s_vaddr, 32'h0000_0100);
        chk("redir102_inst", s_vinst, memword(32'h0000_0100));
`endif

        // Randomized traffic: random grants, latency, decode stalls and redirects
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
        a0 = acc_cnt;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                rpc = $urandom & 32'h0000_FFFC;
                if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
                step(1'b1, rpc);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        chk("random_progress", 32'((acc_cnt - a0) >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
